in_addres_writer: RTL

//  Input-side counterpart of the FFT output address generator. Collects N

---
 rtl/in_addres_writer_if.sv | 24 ++
 rtl/in_addres_writer.sv | 115 +++++++++++
 2 files changed

// File: rtl/in_addres_writer_if.sv
// Sample-capture bus between the UART byte source / RAM side and the
// input address writer. The slave modport is the writer itself.
interface in_addres_writer_if #(
  parameter int SIZE = 4
);
  logic            start_stage;
  logic            rx_valid;
  logic [7:0]      rx_byte;
  logic            en_wr;
  logic [SIZE-1:0] wr_ptr;
  logic [15:0]     wr_data;
  logic            err_timeout;
  logic            done_o;

  modport master (
    output start_stage, rx_valid, rx_byte,
    input  en_wr, wr_ptr, wr_data, err_timeout, done_o
  );

  modport slave (
    input  start_stage, rx_valid, rx_byte,
    output en_wr, wr_ptr, wr_data, err_timeout, done_o
  );
endinterface

// File: rtl/in_addres_writer.sv
// Input address writer: assembles little-endian 16-bit samples from UART
// bytes and writes one frame of N samples to the FFT RAM in natural order.
// A low byte whose high byte does not follow within the timeout is dropped.
module in_addres_writer #(
  parameter int T_1_BIT      = 5207,
  parameter int N            = 16,
  parameter int SIZE         = 4,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  in_addres_writer_if.slave   bus
);

  localparam int              TIMEOUT_CYC = T_1_BIT * TIMEOUT_BITS;
  localparam int              CNT_W       = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_TC     = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [SIZE-1:0] PTR_LAST    = SIZE'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LO,
    S_WAIT_HI,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [7:0]       r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_en_wr;
  logic [SIZE-1:0]  r_wr_ptr;
  logic [15:0]      r_wr_data;
  logic             r_err_timeout;
  logic             r_done;

  // Frame capture FSM with registered outputs and inter-byte timeout counter.
  // NOTE: every register here uses <= so all reads in this block see the
  // pre-edge values, which is what makes the one-cycle pulses line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lo          <= '0;
      r_cnt         <= '0;
      r_en_wr       <= 1'b0;
      r_wr_ptr      <= '0;
      r_wr_data     <= '0;
      r_err_timeout <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each edge; a state raises them only
      // for the single cycle it needs.
      r_en_wr       <= 1'b0;
      r_err_timeout <= 1'b0;
      r_done        <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start_stage) begin
            r_wr_ptr <= '0;
            r_state  <= S_WAIT_LO;
          end
        end

        S_WAIT_LO: begin
          if (bus.rx_valid) begin
            r_lo    <= bus.rx_byte;
            r_cnt   <= '0;
            r_state <= S_WAIT_HI;
          end
        end

        S_WAIT_HI: begin
          // A high byte arriving on the expiry cycle still completes the sample.
          if (bus.rx_valid) begin
            r_wr_data <= {bus.rx_byte, r_lo};
            r_en_wr   <= 1'b1;
            r_state   <= S_WRITE;
          end else if (r_cnt == CNT_TC) begin
            r_err_timeout <= 1'b1;
            r_lo          <= '0;
            r_cnt         <= '0;
            r_state       <= S_WAIT_LO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WRITE: begin
          if (r_wr_ptr == PTR_LAST) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_state  <= S_WAIT_LO;
          end
        end

        S_DONE: begin
          r_wr_ptr <= '0;
          r_state  <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.en_wr       = r_en_wr;
  assign bus.wr_ptr      = r_wr_ptr;
  assign bus.wr_data     = r_wr_data;
  assign bus.err_timeout = r_err_timeout;
  assign bus.done_o      = r_done;

endmodule
